// File: rtl/mvm_lanes_pkg.sv
// Shared types and constants for the mvm_lanes matrix-vector multiplier.
package mvm_lanes_pkg;

  localparam int unsigned DEF_NROWS  = 4;
  localparam int unsigned DEF_NCOLS  = 4;
  localparam int unsigned DEF_NLANES = 2;
  localparam int unsigned DEF_WIDTH  = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_X,
    COMP,
    OUT
  } state_t;

  // Result width that holds NCOLS worst-case products without overflow.
  function automatic int unsigned out_width(input int unsigned width, input int unsigned ncols);
    return 2 * width + $clog2(ncols);
  endfunction

  // Counter width for 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mvm_mac_lane.sv
// One MAC lane: accumulates a*x, presents acc+product on the row's last column and clears.
module mvm_mac_lane
  import mvm_lanes_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned OUT_W = out_width(DEF_WIDTH, DEF_NCOLS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    last,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] x,
  output logic signed [OUT_W-1:0] result,
  output logic                    result_we
);

  logic signed [OUT_W-1:0] r_acc;
  logic signed [OUT_W-1:0] w_prod;

  assign w_prod    = OUT_W'(a) * OUT_W'(x);
  assign result    = r_acc + w_prod;
  assign result_we = en & last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc <= '0;
    end else if (en) begin
      r_acc <= last ? '0 : result;
    end
  end

endmodule

// File: rtl/mvm_lanes.sv
// Matrix-vector multiplier y = A*x with NLANES parallel MAC lanes and stream I/O.
// Build option: define MVM_RELU_EN to clamp negative results to zero when stored.
module mvm_lanes
  import mvm_lanes_pkg::*;
#(
  parameter int unsigned NROWS  = DEF_NROWS,
  parameter int unsigned NCOLS  = DEF_NCOLS,
  parameter int unsigned NLANES = DEF_NLANES,
  parameter int unsigned WIDTH  = DEF_WIDTH
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         s_valid,
  output logic                                         s_ready,
  input  logic signed [WIDTH-1:0]                      s_data,
  input  logic                                         reuse_a,
  output logic                                         m_valid,
  input  logic                                         m_ready,
  output logic signed [out_width(WIDTH, NCOLS)-1:0]    m_data,
  output logic                                         m_last,
  output logic                                         busy
);

  localparam int unsigned OUT_W = out_width(WIDTH, NCOLS);
  localparam int unsigned NA    = NROWS * NCOLS;
  localparam int unsigned NGRP  = NROWS / NLANES;
  localparam int unsigned IW    = cnt_width(NA);
  localparam int unsigned CW    = cnt_width(NCOLS);
  localparam int unsigned GW    = cnt_width(NGRP);
  localparam int unsigned KW    = cnt_width(NROWS);

  state_t r_state;
  state_t w_next;

  logic [IW-1:0] r_idx;
  logic [CW-1:0] r_c;
  logic [GW-1:0] r_g;
  logic [KW-1:0] r_k;
  logic          r_a_loaded;

  logic signed [WIDTH-1:0] r_a   [NA];
  logic signed [WIDTH-1:0] r_x   [NCOLS];
  logic signed [OUT_W-1:0] r_res [NROWS];

  logic w_s_fire, w_m_fire, w_reuse_eff, w_comp;
  logic w_a_last, w_x_last, w_c_last, w_g_last, w_k_last;

  logic signed [OUT_W-1:0] w_result [NLANES];
  logic [NLANES-1:0]       w_we;
  logic [IW-1:0]           w_aidx   [NLANES];
  logic [KW-1:0]           w_row    [NLANES];

  assign w_s_fire    = s_valid & s_ready;
  assign w_m_fire    = m_valid & m_ready;
  assign w_reuse_eff = reuse_a & r_a_loaded;
  assign w_comp      = (r_state == COMP);
  assign w_a_last    = (r_idx == IW'(NA - 1));
  assign w_x_last    = (r_idx == IW'(NCOLS - 1));
  assign w_c_last    = (r_c == CW'(NCOLS - 1));
  assign w_g_last    = (r_g == GW'(NGRP - 1));
  assign w_k_last    = (r_k == KW'(NROWS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state and stream-side decode.
  always_comb begin
    w_next  = r_state;
    s_ready = 1'b0;
    busy    = 1'b0;
    m_valid = 1'b0;
    m_last  = 1'b0;
    m_data  = '0;
    unique case (r_state)
      IDLE: begin
        s_ready = 1'b1;
        if (w_s_fire) begin
          if (w_reuse_eff) begin
            if (NCOLS == 1) w_next = COMP;
            else            w_next = LOAD_X;
          end else begin
            if (NA == 1) w_next = LOAD_X;
            else         w_next = LOAD_A;
          end
        end
      end
      LOAD_A: begin
        s_ready = 1'b1;
        if (w_s_fire && w_a_last) w_next = LOAD_X;
      end
      LOAD_X: begin
        s_ready = 1'b1;
        if (w_s_fire && w_x_last) w_next = COMP;
      end
      COMP: begin
        busy = 1'b1;
        if (w_c_last && w_g_last) w_next = OUT;
      end
      OUT: begin
        busy    = 1'b1;
        m_valid = 1'b1;
        m_last  = w_k_last;
        m_data  = r_res[r_k];
        if (w_m_fire && w_k_last) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Load index, compute counters, output index and the stored-matrix flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx      <= '0;
      r_c        <= '0;
      r_g        <= '0;
      r_k        <= '0;
      r_a_loaded <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: if (w_s_fire) begin
          if (w_reuse_eff) begin
            r_idx <= (NCOLS == 1) ? '0 : IW'(1);
          end else if (NA == 1) begin
            r_idx      <= '0;
            r_a_loaded <= 1'b1;
          end else begin
            r_idx <= IW'(1);
          end
        end
        LOAD_A: if (w_s_fire) begin
          if (w_a_last) begin
            r_idx      <= '0;
            r_a_loaded <= 1'b1;
          end else begin
            r_idx <= r_idx + IW'(1);
          end
        end
        LOAD_X: if (w_s_fire) r_idx <= w_x_last ? '0 : r_idx + IW'(1);
        COMP: begin
          if (w_c_last) begin
            r_c <= '0;
            r_g <= w_g_last ? '0 : r_g + GW'(1);
          end else begin
            r_c <= r_c + CW'(1);
          end
        end
        OUT: if (w_m_fire) r_k <= w_k_last ? '0 : r_k + KW'(1);
        default: ;
      endcase
    end
  end

  // Operand and result buffers keep their contents across reset.
  always_ff @(posedge clk) begin
    if (w_s_fire) begin
      if (r_state == IDLE) begin
        if (w_reuse_eff) r_x[0] <= s_data;
        else             r_a[0] <= s_data;
      end else if (r_state == LOAD_A) begin
        r_a[r_idx] <= s_data;
      end else if (r_state == LOAD_X) begin
        r_x[r_idx[CW-1:0]] <= s_data;
      end
    end
    for (int l = 0; l < NLANES; l++) begin
      if (w_we[l]) begin
`ifdef MVM_RELU_EN
        r_res[w_row[l]] <= w_result[l][OUT_W-1] ? '0 : w_result[l];
`else
        r_res[w_row[l]] <= w_result[l];
`endif
      end
    end
  end

  for (genvar l = 0; l < NLANES; l++) begin : g_lane
    assign w_row[l]  = KW'(32'(r_g) * NLANES + 32'(l));
    assign w_aidx[l] = IW'((32'(r_g) * NLANES + 32'(l)) * NCOLS + 32'(r_c));

    mvm_mac_lane #(
      .WIDTH (WIDTH),
      .OUT_W (OUT_W)
    ) u_lane (
      .clk       (clk),
      .reset     (reset),
      .en        (w_comp),
      .last      (w_c_last),
      .a         (r_a[w_aidx[l]]),
      .x         (r_x[r_c]),
      .result    (w_result[l]),
      .result_we (w_we[l])
    );
  end

endmodule

// File: tb/tb_mvm_lanes.sv
// Self-checking bench for mvm_lanes at default parameters (4x4, 2 lanes, 8-bit).
module tb_mvm_lanes;

  logic clk = 1'b0;
  logic reset, s_valid, s_ready, reuse_a, m_valid, m_ready, m_last, busy;
  logic signed [7:0]  s_data;
  logic signed [17:0] m_data;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int n_acc     = 0;

  typedef logic [15:0][7:0] mat_t;
  typedef logic [3:0][7:0]  vec_t;
  typedef logic [3:0][17:0] res_t;

  typedef struct packed {
    mat_t       a;
    vec_t       x;
    logic       reuse;
    logic       full;
    logic       alt;
    res_t       y;
    logic [7:0] beats;
  } tvec_t;

  tvec_t tv [4];

  mvm_lanes dut (
    .clk     (clk),
    .reset   (reset),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .reuse_a (reuse_a),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_last  (m_last),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (s_valid && s_ready) n_acc++;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
  endtask

  // Reference: plain dot products over the row-major matrix.
  function automatic res_t model(input mat_t a, input vec_t x);
    res_t r;
    for (int row = 0; row < 4; row++) begin
      int s = 0;
      for (int col = 0; col < 4; col++)
        s += int'($signed(a[row*4+col])) * int'($signed(x[col]));
`ifdef MVM_RELU_EN
      if (s < 0) s = 0;
`endif
      r[row] = 18'(s);
    end
    return r;
  endfunction

  task automatic send(input logic [7:0] d, input logic r);
    bit ok = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    reuse_a = r;
    for (int i = 0; i < 60 && !ok; i++) begin
      if (s_ready) ok = 1'b1;
      @(negedge clk);
    end
    s_valid = 1'b0;
    reuse_a = 1'b0;
    if (!ok) begin
      total_cnt++;
      $display("FAIL send_timeout actual=no_accept expected=accept");
    end
  endtask

  task automatic send_stream(input mat_t a, input vec_t x, input logic reuse, input logic full);
    if (full) begin
      for (int i = 0; i < 16; i++) send(a[i], (i == 0) ? reuse : 1'b0);
      for (int i = 0; i < 4; i++)  send(x[i], 1'b0);
    end else begin
      for (int i = 0; i < 4; i++)  send(x[i], (i == 0) ? 1'b1 : 1'b0);
    end
  endtask

  task automatic run_job(input string name, input mat_t a, input vec_t x, input logic reuse,
                         input logic full, input logic alt, input res_t y, input int beats);
    int n0, ncomp, got;
    bit bad, pstall;
    logic signed [17:0] pd;
    logic pl;
    n0 = n_acc; ncomp = 0; got = 0; bad = 1'b0; pstall = 1'b0; pd = '0; pl = 1'b0;
    send_stream(a, x, reuse, full);
    check($sformatf("%s_beats", name), n_acc - n0, beats);
    while (busy && !m_valid && ncomp < 100) begin
      if (s_ready) bad = 1'b1;
      ncomp++;
      @(negedge clk);
    end
    check($sformatf("%s_comp_cycles", name), ncomp, 8);
    for (int cyc = 0; cyc < 200 && got < 4; cyc++) begin
      m_ready = alt ? (cyc % 2 == 0) : 1'b1;
      if (s_ready) bad = 1'b1;
      if (pstall) begin
        check($sformatf("%s_stall_data", name), int'(m_data), int'(pd));
        check($sformatf("%s_stall_last", name), int'(m_last), int'(pl));
      end
      pstall = m_valid && !m_ready;
      pd = m_data;
      pl = m_last;
      if (m_valid && m_ready) begin
        check($sformatf("%s_y%0d", name, got), int'(m_data), int'($signed(y[got])));
        check($sformatf("%s_last%0d", name, got), int'(m_last), int'(got == 3));
        got++;
      end
      @(negedge clk);
    end
    m_ready = 1'b0;
    check($sformatf("%s_n_results", name), got, 4);
    check($sformatf("%s_idle_after", name), int'({m_valid, busy, s_ready}), 1);
    check($sformatf("%s_sready_low", name), int'(bad), 0);
  endtask

  initial begin
    mat_t cur_a, ra;
    vec_t rx;
    logic rreuse, rfull, loaded;

    reset = 1'b1; s_valid = 1'b0; s_data = '0; reuse_a = 1'b0; m_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_s_ready", int'(s_ready), 1);
    check("rst_m_valid", int'(m_valid), 0);
    check("rst_m_data",  int'(m_data), 0);
    check("rst_m_last",  int'(m_last), 0);
    check("rst_busy",    int'(busy), 0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 4; i++) tv[i] = '0;
    // identity, x=[1,2,3,4]
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) tv[0].a[r*4+c] = (r == c) ? 8'd1 : 8'd0;
    for (int i = 0; i < 4; i++) begin tv[0].x[i] = 8'(i + 1); tv[0].y[i] = 18'(i + 1); end
    tv[0].full = 1'b1; tv[0].beats = 8'd20;
    // reuse identity, x=[-1,5,0,7]
    tv[1].x[0] = 8'(-1); tv[1].x[1] = 8'd5; tv[1].x[2] = 8'd0; tv[1].x[3] = 8'd7;
    tv[1].y[0] = 18'(-1); tv[1].y[1] = 18'd5; tv[1].y[2] = 18'd0; tv[1].y[3] = 18'd7;
    tv[1].reuse = 1'b1; tv[1].beats = 8'd4;
    // worst-case magnitude
    for (int i = 0; i < 16; i++) tv[2].a[i] = 8'h80;
    for (int i = 0; i < 4; i++)  begin tv[2].x[i] = 8'h80; tv[2].y[i] = 18'd65536; end
    tv[2].full = 1'b1; tv[2].beats = 8'd20;
    // negative rows, alternating m_ready
    for (int c = 0; c < 4; c++) begin
      tv[3].a[c] = 8'(-1); tv[3].a[4+c] = 8'd2; tv[3].a[8+c] = 8'd3; tv[3].x[c] = 8'd1;
    end
    tv[3].a[12] = 8'd1; tv[3].a[13] = 8'(-2); tv[3].a[14] = 8'd3; tv[3].a[15] = 8'(-4);
`ifdef MVM_RELU_EN
    tv[3].y[0] = 18'd0; tv[3].y[3] = 18'd0;
`else
    tv[3].y[0] = 18'(-4); tv[3].y[3] = 18'(-2);
`endif
    tv[3].y[1] = 18'd8; tv[3].y[2] = 18'd12;
    tv[3].full = 1'b1; tv[3].alt = 1'b1; tv[3].beats = 8'd20;

    for (int i = 0; i < 4; i++)
      run_job($sformatf("vec%0d", i), tv[i].a, tv[i].x, tv[i].reuse, tv[i].full,
              tv[i].alt, tv[i].y, int'(tv[i].beats));

    // reset pulse mid-COMP discards the job and the stored matrix
    send_stream(tv[0].a, tv[0].x, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    check("midcomp_busy", int'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    check("midcomp_rst_state", int'({s_ready, busy, m_valid}), 4);
    reset = 1'b0;
    @(negedge clk);
    run_job("rst_reuse", tv[3].a, tv[1].x, 1'b1, 1'b1, 1'b0, model(tv[3].a, tv[1].x), 20);
    cur_a  = tv[3].a;
    loaded = 1'b1;

    // randomized jobs against the reference model
    for (int j = 0; j < 8; j++) begin
      rreuse = 1'($urandom % 2);
      rfull  = !(rreuse && loaded);
      ra     = cur_a;
      if (rfull) for (int i = 0; i < 16; i++) ra[i] = 8'($urandom);
      for (int i = 0; i < 4; i++) rx[i] = 8'($urandom);
      cur_a = ra;
      run_job($sformatf("rand%0d", j), ra, rx, rreuse, rfull, 1'($urandom % 2),
              model(ra, rx), rfull ? 20 : 4);
      loaded = 1'b1;
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
